vend_dispenser: RTL and testbench

Output-side actuator controller for the vending machine FSM: consumes the single-cycle `Open`/`Change` vend pulses and drives the product-door solenoid and a 4-phase handshake to the nickel ejector. It keeps a nickel inventory count, flags empty and fault conditions, and sits between the coin FSM and the physical dispense hardware.

---
 rtl/vend_dispenser_if.sv | 38 +++
 rtl/vend_dispenser.sv | 129 ++++++++++++
 tb/tb_vend_dispenser.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispenser_if.sv
// vend_dispenser_if
//   Groups the vend-side and ejector-side signals of the dispenser.
//   master : the environment (coin FSM, technician panel, nickel ejector).
//   slave  : the dispenser controller.
//   Signals:
//     Open, Change     vend pulse and change-owed qualifier
//     Load             technician reload pulse
//     EjectAck         ejector acknowledge (4-phase)
//     DoorOut          product door solenoid
//     EjectReq         ejector request (4-phase)
//     Busy, Empty      status flags
//     Fault, Overrun   sticky error flags
//     Nickels          nickel inventory count
interface vend_dispenser_if #(
    parameter int unsigned CNT_W = 4
);
    logic             Open;
    logic             Change;
    logic             Load;
    logic             EjectAck;
    logic             DoorOut;
    logic             EjectReq;
    logic             Busy;
    logic             Empty;
    logic             Fault;
    logic             Overrun;
    logic [CNT_W-1:0] Nickels;

    modport master (
        output Open, Change, Load, EjectAck,
        input  DoorOut, EjectReq, Busy, Empty, Fault, Overrun, Nickels
    );

    modport slave (
        input  Open, Change, Load, EjectAck,
        output DoorOut, EjectReq, Busy, Empty, Fault, Overrun, Nickels
    );
endinterface

// File: rtl/vend_dispenser.sv
// vend_dispenser
//   Output-side actuator controller for the vending machine. Turns the
//   single-cycle Open/Change vend pulse into a DOOR_CYCLES-long door
//   solenoid pulse, then (if change is owed and a nickel is in stock) runs a
//   4-phase request/acknowledge handshake with the nickel ejector. Tracks the
//   nickel inventory and raises sticky Fault / Overrun flags.
//   Ports:
//     Clock  : rising-edge clock
//     Reset  : asynchronous active-high reset
//     bus    : vend_dispenser_if.slave (Open, Change, Load, EjectAck in;
//              DoorOut, EjectReq, Busy, Empty, Fault, Overrun, Nickels out)
//   All outputs are decoded from registered state only.
module vend_dispenser #(
    parameter int unsigned DOOR_CYCLES = 4,
    parameter int unsigned NICKEL_MAX  = 15,
    parameter int unsigned CNT_W       = 4
) (
    input logic             Clock,
    input logic             Reset,
    vend_dispenser_if.slave bus
);

    localparam int unsigned DCW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DOOR,
        EJECT,
        RELEASE
    } state_t;

    state_t           state,       state_nxt;
    logic [DCW-1:0]   door_cnt,    door_cnt_nxt;
    logic             change_owed, change_owed_nxt;
    logic [CNT_W-1:0] nickels,     nickels_nxt;
    logic             fault,       fault_nxt;
    logic             overrun,     overrun_nxt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            door_cnt    <= '0;
            change_owed <= 1'b0;
            nickels     <= '0;
            fault       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            door_cnt    <= door_cnt_nxt;
            change_owed <= change_owed_nxt;
            nickels     <= nickels_nxt;
            fault       <= fault_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        door_cnt_nxt    = door_cnt;
        change_owed_nxt = change_owed;
        nickels_nxt     = nickels;
        fault_nxt       = fault;
        overrun_nxt     = overrun;

        case (state)
            IDLE: begin
                if (bus.Open) begin
                    change_owed_nxt = bus.Change;
                    door_cnt_nxt    = DCW'(DOOR_CYCLES);
                    state_nxt       = DOOR;
                end
            end
            DOOR: begin
                door_cnt_nxt = door_cnt - DCW'(1);
                // Counter value 1 marks the last cycle of the door pulse.
                if (door_cnt == DCW'(1)) begin
                    if (!change_owed) begin
                        state_nxt = IDLE;
                    end else if (nickels != '0) begin
                        state_nxt = EJECT;
                    end else begin
                        fault_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            EJECT: begin
                if (bus.EjectAck) begin
                    if (nickels != '0) begin
                        nickels_nxt = nickels - CNT_W'(1);
                    end
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // Return-to-zero phase: ack must drop before the next request.
                if (!bus.EjectAck) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A vend request outside IDLE is dropped and flagged.
        if (bus.Open && (state != IDLE)) begin
            overrun_nxt = 1'b1;
        end

        // Reload overrides any same-cycle decrement and clears Fault,
        // without touching the FSM or the handshake.
        if (bus.Load) begin
            nickels_nxt = CNT_W'(NICKEL_MAX);
            fault_nxt   = 1'b0;
        end
    end

    always_comb begin
        bus.DoorOut  = (state == DOOR);
        bus.EjectReq = (state == EJECT);
        bus.Busy     = (state != IDLE);
        bus.Empty    = (nickels == '0);
        bus.Fault    = fault;
        bus.Overrun  = overrun;
        bus.Nickels  = nickels;
    end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser
//   Self-checking bench for vend_dispenser. The reference is a
//   transaction-level model: inventory, Fault and Overrun are tracked as
//   plain variables, and per-cycle output expectations come from the
//   timing rules (door length, ack delay, ack hold) of each vend.
module tb_vend_dispenser;

    localparam int unsigned DC   = 4;
    localparam int unsigned NMAX = 15;
    localparam int unsigned CW   = 4;

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    vend_dispenser_if #(.CNT_W(CW)) bus ();

    vend_dispenser #(
        .DOOR_CYCLES(DC),
        .NICKEL_MAX (NMAX),
        .CNT_W      (CW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    int unsigned m_nick;
    bit          m_fault;
    bit          m_ovr;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [CW-1:0] obs, input int unsigned exp);
        logic [CW-1:0] e;
        e = CW'(exp);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic status(input string tag);
        chkn({tag, ".nickels"}, bus.Nickels, m_nick);
        chk1({tag, ".empty"},   bus.Empty,   m_nick == 0);
        chk1({tag, ".fault"},   bus.Fault,   m_fault);
        chk1({tag, ".overrun"}, bus.Overrun, m_ovr);
    endtask

    task automatic do_load();
        bus.Load = 1'b1;
        tick();
        bus.Load = 1'b0;
        m_nick  = NMAX;
        m_fault = 1'b0;
        status("load");
    endtask

    // One full vend. dly: idle cycles before ack rises; hold: cycles ack stays
    // high; load_ack: pulse Load with the first ack; ovr_door: door-cycle index
    // at which a stray Open is injected (-1 none); ovr_ej: stray Open in EJECT.
    task automatic vend(input bit change, input int unsigned dly, input int unsigned hold,
                        input bit load_ack, input int ovr_door, input bit ovr_ej);
        bus.Open   = 1'b1;
        bus.Change = change;
        tick();
        bus.Open   = 1'b0;
        bus.Change = 1'b0;
        for (int i = 0; i < int'(DC); i++) begin
            chk1("door.doorout",  bus.DoorOut,  1'b1);
            chk1("door.busy",     bus.Busy,     1'b1);
            chk1("door.ejectreq", bus.EjectReq, 1'b0);
            status("door");
            if (i == ovr_door) begin
                bus.Open   = 1'b1;
                bus.Change = ~change;
                m_ovr      = 1'b1;
            end
            tick();
            bus.Open   = 1'b0;
            bus.Change = 1'b0;
        end
        chk1("post.doorout", bus.DoorOut, 1'b0);
        if (!change || m_nick == 0) begin
            if (change) m_fault = 1'b1;
            chk1("post.busy",     bus.Busy,     1'b0);
            chk1("post.ejectreq", bus.EjectReq, 1'b0);
            status("post");
        end else begin
            chk1("ej.ejectreq", bus.EjectReq, 1'b1);
            chk1("ej.busy",     bus.Busy,     1'b1);
            for (int j = 0; j < int'(dly); j++) begin
                if (ovr_ej && j == 0) begin
                    bus.Open = 1'b1;
                    m_ovr    = 1'b1;
                end
                tick();
                bus.Open = 1'b0;
                chk1("ejwait.ejectreq", bus.EjectReq, 1'b1);
                chk1("ejwait.busy",     bus.Busy,     1'b1);
            end
            bus.EjectAck = 1'b1;
            bus.Load     = load_ack;
            tick();
            bus.Load = 1'b0;
            if (load_ack) begin
                m_nick  = NMAX;
                m_fault = 1'b0;
            end else begin
                m_nick = m_nick - 1;
            end
            chk1("ack.ejectreq", bus.EjectReq, 1'b0);
            chk1("ack.busy",     bus.Busy,     1'b1);
            status("ack");
            for (int j = 1; j < int'(hold); j++) begin
                tick();
                chk1("hold.busy",     bus.Busy,     1'b1);
                chk1("hold.ejectreq", bus.EjectReq, 1'b0);
            end
            bus.EjectAck = 1'b0;
            tick();
            chk1("rel.busy",     bus.Busy,     1'b0);
            chk1("rel.ejectreq", bus.EjectReq, 1'b0);
            status("rel");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        bus.Open     = 1'b0;
        bus.Change   = 1'b0;
        bus.Load     = 1'b0;
        bus.EjectAck = 1'b0;
        m_nick  = 0;
        m_fault = 1'b0;
        m_ovr   = 1'b0;
        #12;
        chk1("reset.doorout",  bus.DoorOut,  1'b0);
        chk1("reset.ejectreq", bus.EjectReq, 1'b0);
        chk1("reset.busy",     bus.Busy,     1'b0);
        status("reset");
        Reset = 1'b0;
        tick();

        // Load then plain vend (no change).
        do_load();
        repeat (3) tick();
        vend(1'b0, 0, 1, 1'b0, -1, 1'b0);

        // Vend with change, delayed ack and held ack.
        vend(1'b1, 2, 2, 1'b0, -1, 1'b0);

        // Change owed with empty inventory -> Fault, then reload clears it.
        Reset = 1'b1;
        #3;
        Reset = 1'b0;
        m_nick = 0; m_fault = 1'b0; m_ovr = 1'b0;
        tick();
        vend(1'b1, 0, 1, 1'b0, -1, 1'b0);
        chk1("fault.raised", bus.Fault, 1'b1);
        do_load();

        // Stray Open during DOOR and during EJECT.
        vend(1'b1, 2, 1, 1'b0, 1, 1'b1);
        tick();
        status("overrun.sticky");

        // Load in the same cycle the ack is first sampled.
        vend(1'b1, 0, 1, 1'b1, -1, 1'b0);

        // Back-to-back vends at minimum spacing.
        vend(1'b0, 0, 1, 1'b0, -1, 1'b0);
        vend(1'b1, 0, 1, 1'b0, -1, 1'b0);
        vend(1'b0, 0, 1, 1'b0, -1, 1'b0);

        // Async reset mid-EJECT, between clock edges.
        bus.Open   = 1'b1;
        bus.Change = 1'b1;
        tick();
        bus.Open   = 1'b0;
        bus.Change = 1'b0;
        repeat (DC) tick();
        chk1("arst.pre_ejectreq", bus.EjectReq, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        m_nick = 0; m_fault = 1'b0; m_ovr = 1'b0;
        chk1("arst.ejectreq", bus.EjectReq, 1'b0);
        chk1("arst.doorout",  bus.DoorOut,  1'b0);
        chk1("arst.busy",     bus.Busy,     1'b0);
        status("arst");
        #1;
        Reset = 1'b0;
        tick();
        do_load();
        vend(1'b0, 0, 1, 1'b0, -1, 1'b0);

        // Randomized vends against the model.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.Change = 1'($urandom_range(0, 1));
                tick();
                chk1("gap.busy", bus.Busy, 1'b0);
            end
            bus.Change = 1'b0;
            if ($urandom_range(0, 7) == 0) do_load();
            vend(1'($urandom_range(0, 1)),
                 $urandom_range(0, 4),
                 $urandom_range(1, 3),
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DC - 1)) : -1,
                 $urandom_range(0, 5) == 0);
        end

        // Drain the inventory to zero, then one more change vend faults.
        do_load();
        for (int n = 0; n < int'(NMAX); n++) begin
            vend(1'b1, 0, 1, 1'b0, -1, 1'b0);
        end
        chk1("drain.empty", bus.Empty, 1'b1);
        vend(1'b1, 0, 1, 1'b0, -1, 1'b0);
        chkn("drain.nickels", bus.Nickels, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
